// File: rtl/fir_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fir_serial_pkg
// Brief   : Shared types and helpers for the FIR serial word link.
// Revision: 1.0 - initial release
// ============================================================================
package fir_serial_pkg;

   localparam int c_DEFAULT_DATA_WIDTH = 24;

   typedef enum logic [0:0] {
      ST_RX    = 1'b0,
      ST_STALL = 1'b1
   } rx_state_e;

   // Bit counter width; never below one bit so single-bit words still elaborate.
   function automatic int cnt_width(input int data_width);
      return (data_width > 1) ? $clog2(data_width) : 1;
   endfunction

endpackage : fir_serial_pkg
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : serial_shift_reg
// Brief   : Indexed bit-write collector for serial words, selectable bit order.
// Revision: 1.0 - initial release
// ============================================================================
module serial_shift_reg
   import fir_serial_pkg::*;
#(
   parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
   parameter bit LSB_FIRST  = 1'b1,
   parameter int CNT_W      = cnt_width(DATA_WIDTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [CNT_W-1:0]      i_bit_idx,
   input  logic                  i_bit,
   output logic [DATA_WIDTH-1:0] o_shift,
   output logic [DATA_WIDTH-1:0] o_shift_nxt
);

   logic [CNT_W-1:0]      w_pos;
   logic [DATA_WIDTH-1:0] r_shift;

   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign w_pos = i_bit_idx;
      end else begin : g_msb_first
         assign w_pos = CNT_W'(DATA_WIDTH - 1) - i_bit_idx;
      end
   endgenerate

   // Next value is exported so the owner can capture a word including its final bit.
   always_comb begin
      o_shift_nxt = r_shift;
      if (i_wr_en) begin
         o_shift_nxt[w_pos] = i_bit;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift <= '0;
      end else begin
         r_shift <= o_shift_nxt;
      end
   end

   assign o_shift = r_shift;

endmodule : serial_shift_reg
`default_nettype wire

// File: rtl/serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module  : serial_word_rx
// Brief   : Bit-serial to parallel word receiver with one-word holding register.
// Revision: 1.0 - initial release
// ============================================================================
module serial_word_rx
   import fir_serial_pkg::*;
#(
   parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_din,
   input  logic                  i_din_valid,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_word,
   output logic                  o_word_valid,
   input  logic                  i_word_ready,
   output logic                  o_overrun
);

   localparam int               CNT_W      = cnt_width(DATA_WIDTH);
   localparam logic [0:0]       c_ST_RX    = ST_RX;
   localparam logic [0:0]       c_ST_STALL = ST_STALL;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [0:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_word;
   logic                  r_word_valid;
   logic                  r_overrun;

   logic                  w_in_rx;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_drain;
   logic [DATA_WIDTH-1:0] w_shift;
   logic [DATA_WIDTH-1:0] w_shift_nxt;

   assign w_in_rx  = (r_state == c_ST_RX);
   assign w_accept = i_en & i_din_valid & w_in_rx;
   assign w_last   = w_accept & (r_cnt == c_CNT_LAST);
   assign w_drain  = r_word_valid & i_word_ready;

   serial_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .LSB_FIRST  (LSB_FIRST),
      .CNT_W      (CNT_W)
   ) u_shift (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr_en     (w_accept),
      .i_bit_idx   (r_cnt),
      .i_bit       (i_din),
      .o_shift     (w_shift),
      .o_shift_nxt (w_shift_nxt)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= c_ST_RX;
         r_cnt        <= '0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else if (i_en) begin
         case (r_state)
            c_ST_RX: begin
               if (w_last) begin
                  // A drain on the same edge frees the holding register for the new word.
                  if (!r_word_valid || i_word_ready) begin
                     r_word       <= w_shift_nxt;
                     r_word_valid <= 1'b1;
                     r_cnt        <= '0;
                  end else begin
                     r_state <= c_ST_STALL;
                  end
               end else begin
                  if (w_accept) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
                  if (w_drain) begin
                     r_word_valid <= 1'b0;
                  end
               end
            end
            c_ST_STALL: begin
               if (i_din_valid) begin
                  r_overrun <= 1'b1;
               end
               if (w_drain) begin
                  r_word  <= w_shift;
                  r_cnt   <= '0;
                  r_state <= c_ST_RX;
               end
            end
            default: begin
               r_state <= c_ST_RX;
            end
         endcase
      end
   end

   assign o_ready      = i_rst_n & w_in_rx;
   assign o_word       = r_word;
   assign o_word_valid = r_word_valid;
   assign o_overrun    = r_overrun;

endmodule : serial_word_rx
`default_nettype wire

// File: tb/tb_serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_word_rx
// Brief   : Self-checking bench for serial_word_rx in both bit orders.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_word_rx;

   localparam int DW = 24;

   logic tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   logic rst_n = 1'b0;
   logic en = 1'b0, dv = 1'b0, din = 1'b0, wr = 1'b0;
   logic chk_on = 1'b0;

   logic          ready_l, valid_l, ovr_l, ready_m, valid_m, ovr_m;
   logic [DW-1:0] word_l, word_m;

   serial_word_rx #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) dut_lsb (
      .i_clk(tb_clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(dv),
      .o_ready(ready_l), .o_word(word_l), .o_word_valid(valid_l),
      .i_word_ready(wr), .o_overrun(ovr_l)
   );

   serial_word_rx #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) dut_msb (
      .i_clk(tb_clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(dv),
      .o_ready(ready_m), .o_word(word_m), .o_word_valid(valid_m),
      .i_word_ready(wr), .o_overrun(ovr_m)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: bits collected so far, a finished word awaiting space, and the holding register.
   bit            q[$];
   logic          pend = 1'b0;
   logic          hv = 1'b0;
   logic          ovr = 1'b0;
   logic [DW-1:0] hw_l = '0, hw_m = '0, pw_l = '0, pw_m = '0;
   logic          m_ready;
   assign m_ready = rst_n && !pend;

   function automatic logic [DW-1:0] pack(input bit lsb);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < DW; k++) r[lsb ? k : DW-1-k] = q[k];
      return r;
   endfunction

   always @(posedge tb_clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         pend = 1'b0; hv = 1'b0; ovr = 1'b0; hw_l = '0; hw_m = '0;
      end else if (en) begin
         if (pend) begin
            if (dv) ovr = 1'b1;
            if (wr) begin
               hw_l = pw_l; hw_m = pw_m; pend = 1'b0; q.delete();
            end
         end else if (dv) begin
            q.push_back(din);
            if (q.size() == DW) begin
               pw_l = pack(1'b1); pw_m = pack(1'b0);
               if (!hv || wr) begin
                  hw_l = pw_l; hw_m = pw_m; hv = 1'b1; q.delete();
               end else begin
                  pend = 1'b1;
               end
            end else if (hv && wr) begin
               hv = 1'b0;
            end
         end else if (hv && wr) begin
            hv = 1'b0;
         end
      end
   end

   always @(negedge tb_clk) begin
      if (chk_on) begin
         check("ready_l", ready_l, m_ready);
         check("ready_m", ready_m, m_ready);
         check("valid_l", valid_l, hv);
         check("valid_m", valid_m, hv);
         check("word_l",  word_l,  hw_l);
         check("word_m",  word_m,  hw_m);
         check("ovr_l",   ovr_l,   ovr);
         check("ovr_m",   ovr_m,   ovr);
      end
   end

   task automatic step(input logic e, input logic v, input logic d, input logic r);
      en = e; dv = v; din = d; wr = r;
      @(negedge tb_clk);
   endtask

   task automatic send_bits(input logic [DW-1:0] w, input int first, input int last, input logic r);
      for (int k = first; k <= last; k++) step(1'b1, 1'b1, w[k], r);
   endtask

   logic [DW-1:0] w;

   initial begin
      @(negedge tb_clk);
      @(negedge tb_clk);
      check("rst_ready_low", ready_l, 1'b0);
      check("rst_word", word_l, '0);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      #1 check("rst_ready_high", ready_l, 1'b1);
      @(negedge tb_clk);

      // Continuous word, downstream always ready
      w = 24'h00A5C3;
      send_bits(w, 0, DW-2, 1'b1);
      check("t1_pre_valid", valid_l, 1'b0);
      send_bits(w, DW-1, DW-1, 1'b1);
      check("t1_valid", valid_l, 1'b1);
      check("t1_word", word_l, 24'h00A5C3);
      check("t1_ready", ready_l, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("t1_drained", valid_l, 1'b0);

      // Bit ordering
      w = 24'h000001;
      send_bits(w, 0, DW-1, 1'b1);
      check("t2_msb_word", word_m, 24'h800000);
      check("t2_lsb_word", word_l, 24'h000001);
      step(1'b1, 1'b0, 1'b0, 1'b1);

      // Backpressure, stall and overrun
      w = 24'h111111;
      send_bits(w, 0, DW-1, 1'b0);
      w = 24'h222222;
      send_bits(w, 0, DW-1, 1'b0);
      check("t3_hold_word", word_l, 24'h111111);
      check("t3_stall_ready", ready_l, 1'b0);
      check("t3_ovr_before", ovr_l, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      check("t3_ovr", ovr_l, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("t3_word2", word_l, 24'h222222);
      check("t3_valid2", valid_l, 1'b1);
      check("t3_ready2", ready_l, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);

      // Gap mid-word
      w = 24'hABCDEF;
      send_bits(w, 0, 11, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'($urandom), 1'b1);
      send_bits(w, 12, DW-1, 1'b1);
      check("t4_word", word_l, 24'hABCDEF);

      // Asynchronous reset mid-word
      w = 24'h123456;
      send_bits(w, 0, 9, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_word_l", word_l, '0);
      check("t5_rst_word_m", word_m, '0);
      check("t5_rst_valid", valid_l, 1'b0);
      check("t5_rst_ovr", ovr_l, 1'b0);
      check("t5_rst_ready", ready_l, 1'b0);
      @(negedge tb_clk);
      rst_n = 1'b1;
      w = 24'h0F0F0F;
      send_bits(w, 0, DW-1, 1'b1);
      check("t5_word", word_l, 24'h0F0F0F);

      // Enable low mid-word while the line toggles
      w = 24'h5A5A5A;
      send_bits(w, 0, 9, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'(i), 1'b1);
      send_bits(w, 10, DW-1, 1'b1);
      check("t6_word", word_l, 24'h5A5A5A);
      step(1'b1, 1'b0, 1'b0, 1'b1);

      // Random traffic against the reference
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
              1'($urandom), ($urandom_range(0, 1) == 1));
      end

      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_word_rx
`default_nettype wire
